// File: rtl/mio_mem_responder.sv
// Memory/IO responder: serves one CPU load/store at a time, WAIT_CYCLES wait states, sized RAM access.
// Optional MIO_ALIGN_CHECK_EN: misaligned word/half accesses are rejected with addr_err.
module mio_mem_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        CPU_MIO,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  RAMCtrl,
    input  logic [31:0] addr,
    input  logic [31:0] Data_out,
    output logic [31:0] Data_in,
    output logic        MIO_ready,
    output logic        busy,
    output logic        addr_err
);
    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned CntW  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StResp} state_t;

    state_t                state_q;
    logic [CntW-1:0]       cnt_q;
    logic                  we_q;
    logic [2:0]            ctrl_q;
    logic [ADDR_WIDTH+1:0] addr_q;
    logic [31:0]           wdata_q;

    logic [31:0]           mem [Depth];
    logic [ADDR_WIDTH-1:0] idx;
    logic [31:0]           rd_word;
    logic [15:0]           half_lane;
    logic [7:0]            byte_lane;
    logic [31:0]           load_val;
    logic [31:0]           wr_word;
    logic                  misaligned;
    logic                  acc_err;

    // Upper address bits wrap modulo the RAM size.
    logic unused_addr;
    assign unused_addr = ^addr[31:ADDR_WIDTH+2];

    // Elaboration-time image: RAM zero-filled.
    initial begin
        for (int i = 0; i < int'(Depth); i++) mem[i] = '0;
    end

    assign idx     = addr_q[ADDR_WIDTH+1:2];
    assign rd_word = mem[idx];

    always_comb begin
        half_lane = rd_word[{addr_q[1], 4'b0000} +: 16];
        byte_lane = rd_word[{addr_q[1:0], 3'b000} +: 8];
`ifdef MIO_ALIGN_CHECK_EN
        misaligned = ((ctrl_q == 3'b000) && (addr_q[1:0] != 2'b00))
                   || (((ctrl_q == 3'b001) || (ctrl_q == 3'b010)) && addr_q[0]);
`else
        misaligned = 1'b0;
`endif
        acc_err  = (ctrl_q > 3'd4) || misaligned;
        load_val = rd_word;
        wr_word  = rd_word;
        case (ctrl_q)
            3'b000: wr_word = wdata_q;
            3'b001, 3'b010: begin
                load_val = ctrl_q[0] ? {{16{half_lane[15]}}, half_lane} : {16'h0, half_lane};
                wr_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            end
            3'b011, 3'b100: begin
                load_val = ctrl_q[0] ? {{24{byte_lane[7]}}, byte_lane} : {24'h0, byte_lane};
                wr_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            end
            default: ;
        endcase
    end

    // A reset coinciding with the ACCESS edge also suppresses the commit.
    always_ff @(posedge clk) begin
        if (rst && (state_q == StAccess) && we_q && !acc_err) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            MIO_ready <= 1'b0;
            busy      <= 1'b0;
            addr_err  <= 1'b0;
            Data_in   <= '0;
            we_q      <= 1'b0;
            ctrl_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            MIO_ready <= 1'b0;
            addr_err  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (CPU_MIO && (MemRead || MemWrite)) begin
                        we_q    <= MemWrite;
                        ctrl_q  <= RAMCtrl;
                        addr_q  <= addr[ADDR_WIDTH+1:0];
                        wdata_q <= Data_out;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= (WAIT_CYCLES == 0) ? StAccess : StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        state_q <= StAccess;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StAccess: begin
                    if (!we_q && !acc_err) Data_in <= load_val;
                    MIO_ready <= 1'b1;
                    addr_err  <= acc_err;
                    busy      <= 1'b0;
                    state_q   <= StResp;
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_mio_mem_responder.sv
// Scoreboard bench for mio_mem_responder: one instance with two wait states, one with none.
module tb_mio_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cpu_mio, mem_read, mem_write;
    logic [2:0]  ram_ctrl;
    logic [31:0] addr, data_out;
    logic [31:0] data_in;
    logic        mio_ready, busy, addr_err;

    logic        cpu_mio0, mem_read0, mem_write0;
    logic [2:0]  ram_ctrl0;
    logic [31:0] addr0, data_out0;
    logic [31:0] data_in0;
    logic        mio_ready0, busy0, addr_err0;

    mio_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .CPU_MIO(cpu_mio), .MemRead(mem_read), .MemWrite(mem_write),
        .RAMCtrl(ram_ctrl), .addr(addr), .Data_out(data_out), .Data_in(data_in),
        .MIO_ready(mio_ready), .busy(busy), .addr_err(addr_err)
    );

    mio_mem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .CPU_MIO(cpu_mio0), .MemRead(mem_read0), .MemWrite(mem_write0),
        .RAMCtrl(ram_ctrl0), .addr(addr0), .Data_out(data_out0), .Data_in(data_in0),
        .MIO_ready(mio_ready0), .busy(busy0), .addr_err(addr_err0)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] last_load = '0;

    // Drives one request on the two-wait-state instance and holds it until MIO_ready.
    task automatic issue(input logic rd, input logic wr, input logic [2:0] ctrl,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] exp_data, input logic exp_err,
                         output int lat, output logic [31:0] got, output logic got_err,
                         output logic got_busy);
        @(negedge clk);
        cpu_mio = 1'b1; mem_read = rd; mem_write = wr; ram_ctrl = ctrl; addr = a; data_out = d;
        sb.push_back('{data: exp_data, err: exp_err});
        lat = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (mio_ready) begin
                lat = k;
                break;
            end
        end
        got = data_in; got_err = addr_err; got_busy = busy;
        cpu_mio = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({mio_ready, busy, addr_err} !== 3'b000 || data_in !== 32'h0) begin
            miscompares++;
            $display("FAIL reset rdy/busy/err=%b data=%h want 000 00000000",
                     {mio_ready, busy, addr_err}, data_in);
        end
        vectors++;
        if ({mio_ready0, busy0, addr_err0} !== 3'b000 || data_in0 !== 32'h0) begin
            miscompares++;
            $display("FAIL reset0 rdy/busy/err=%b data=%h want 000 00000000",
                     {mio_ready0, busy0, addr_err0}, data_in0);
        end
        rst = 1'b1;
    endtask

    task automatic test_word();
        int lat; logic [31:0] got; logic err, bsy;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) last_load = 32'hDEADBEEF;
            issue(i == 1, i == 0, 3'b000, 32'h10, 32'hDEADBEEF, last_load, 1'b0, lat, got, err, bsy);
            e = sb.pop_front();
            vectors++;
            if (lat !== 4) begin
                miscompares++; $display("FAIL word[%0d] latency got %0d want 4", i, lat);
            end
            vectors++;
            if (got !== e.data || err !== e.err || bsy !== 1'b0) begin
                miscompares++;
                $display("FAIL word[%0d] data/err/busy got %h %b %b want %h %b 0",
                         i, got, err, bsy, e.data, e.err);
            end
        end
    endtask

    task automatic test_sizes();
        int lat; logic [31:0] got; logic err, bsy;
        logic [31:0] a_tab [4] = '{32'h22, 32'h22, 32'h20, 32'h21};
        logic [2:0]  c_tab [4] = '{3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] x_tab [4] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'h0000007F};
        issue(1'b0, 1'b1, 3'b000, 32'h20, 32'h80017F80, last_load, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        for (int i = 0; i < 4; i++) begin
            last_load = x_tab[i];
            issue(1'b1, 1'b0, c_tab[i], a_tab[i], 32'h0, x_tab[i], 1'b0, lat, got, err, bsy);
            e = sb.pop_front();
            vectors++;
            if (got !== e.data || err !== e.err) begin
                miscompares++;
                $display("FAIL sizes[%0d] got %h err %b want %h err %b", i, got, err, e.data, e.err);
            end
        end
    endtask

    task automatic test_merge();
        int lat; logic [31:0] got; logic err, bsy;
        issue(1'b0, 1'b1, 3'b000, 32'h30, 32'h11223344, last_load, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        issue(1'b0, 1'b1, 3'b001, 32'h32, 32'hFFFFAAAA, last_load, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        // Both strobes high: the store must win.
        issue(1'b1, 1'b1, 3'b011, 32'h30, 32'hFFFFFF55, last_load, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data) begin
            miscompares++; $display("FAIL merge_store Data_in got %h want %h", got, e.data);
        end
        last_load = 32'hAAAA3355;
        issue(1'b1, 1'b0, 3'b000, 32'h30, 32'h0, 32'hAAAA3355, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err) begin
            miscompares++;
            $display("FAIL merge got %h err %b want %h err %b", got, err, e.data, e.err);
        end
    endtask

    task automatic test_align();
        int lat; logic [31:0] got; logic err, bsy;
        last_load = 32'h80017F80;
        issue(1'b1, 1'b0, 3'b000, 32'h20, 32'h0, 32'h80017F80, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
`ifdef MIO_ALIGN_CHECK_EN
        issue(1'b1, 1'b0, 3'b000, 32'h31, 32'h0, last_load, 1'b1, lat, got, err, bsy);
`else
        last_load = 32'hAAAA3355;
        issue(1'b1, 1'b0, 3'b000, 32'h31, 32'h0, 32'hAAAA3355, 1'b0, lat, got, err, bsy);
`endif
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err || lat !== 4) begin
            miscompares++;
            $display("FAIL misalign got %h err %b lat %0d want %h err %b lat 4",
                     got, err, lat, e.data, e.err);
        end
        // Address bits above the RAM wrap: 0x1000 + 0x20 aliases 0x20.
        last_load = 32'h80017F80;
        issue(1'b1, 1'b0, 3'b000, 32'h1020, 32'h0, 32'h80017F80, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err) begin
            miscompares++; $display("FAIL wrap got %h err %b want %h err %b", got, err, e.data, e.err);
        end
    endtask

    task automatic test_reserved();
        int lat; logic [31:0] got; logic err, bsy;
        issue(1'b1, 1'b0, 3'b101, 32'h30, 32'h0, last_load, 1'b1, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err) begin
            miscompares++; $display("FAIL rsv_load got %h err %b want %h err %b", got, err, e.data, e.err);
        end
        issue(1'b0, 1'b1, 3'b111, 32'h30, 32'h0, last_load, 1'b1, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err) begin
            miscompares++; $display("FAIL rsv_store got %h err %b want %h err %b", got, err, e.data, e.err);
        end
        last_load = 32'hAAAA3355;
        issue(1'b1, 1'b0, 3'b000, 32'h30, 32'h0, 32'hAAAA3355, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err) begin
            miscompares++; $display("FAIL rsv_noWrite got %h err %b want %h err %b", got, err, e.data, e.err);
        end
    endtask

    task automatic test_abort();
        int lat; logic [31:0] got; logic err, bsy; logic seen;
        issue(1'b0, 1'b1, 3'b000, 32'h40, 32'hCAFEF00D, last_load, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        @(negedge clk);
        cpu_mio = 1'b1; mem_write = 1'b1; ram_ctrl = 3'b000; addr = 32'h40; data_out = 32'h12345678;
        @(negedge clk);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++; $display("FAIL abort_busy got %b want 1", busy);
        end
        rst = 1'b0; cpu_mio = 1'b0; mem_write = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 2) rst = 1'b1;
            seen |= mio_ready;
        end
        last_load = 32'h0;
        vectors++;
        if (seen !== 1'b0 || busy !== 1'b0 || data_in !== 32'h0) begin
            miscompares++;
            $display("FAIL abort ready_seen %b busy %b data %h want 0 0 00000000", seen, busy, data_in);
        end
        last_load = 32'hCAFEF00D;
        issue(1'b1, 1'b0, 3'b000, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0, lat, got, err, bsy);
        e = sb.pop_front();
        vectors++;
        if (got !== e.data || err !== e.err) begin
            miscompares++; $display("FAIL abort_load got %h err %b want %h err %b", got, err, e.data, e.err);
        end
    endtask

    task automatic test_back_to_back();
        int lat, first, second; logic seen, bsy_seen;
        @(negedge clk);
        cpu_mio0 = 1'b1; mem_write0 = 1'b1; ram_ctrl0 = 3'b000; addr0 = 32'h8; data_out0 = 32'h5A5A0001;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (mio_ready0) begin lat = k; break; end
        end
        mem_write0 = 1'b0; cpu_mio0 = 1'b0;
        vectors++;
        if (lat !== 2) begin
            miscompares++; $display("FAIL b2b_store latency got %0d want 2", lat);
        end
        @(negedge clk);
        cpu_mio0 = 1'b1; mem_read0 = 1'b1;
        sb.push_back('{data: 32'h5A5A0001, err: 1'b0});
        sb.push_back('{data: 32'h5A5A0001, err: 1'b0});
        first = 0; second = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (mio_ready0) begin
                e = sb.pop_front();
                vectors++;
                if (data_in0 !== e.data || addr_err0 !== e.err) begin
                    miscompares++;
                    $display("FAIL b2b_load got %h err %b want %h err %b", data_in0, addr_err0, e.data, e.err);
                end
                if (first == 0) first = k;
                else begin second = k; break; end
            end
        end
        vectors++;
        if (first !== 2 || second !== 5) begin
            miscompares++; $display("FAIL b2b_timing got %0d,%0d want 2,5", first, second);
        end
        cpu_mio0 = 1'b0;
        seen = 1'b0; bsy_seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen |= mio_ready0; bsy_seen |= busy0;
        end
        mem_read0 = 1'b0;
        vectors++;
        if (seen !== 1'b0 || bsy_seen !== 1'b0) begin
            miscompares++; $display("FAIL no_cpu_mio ready %b busy %b want 0 0", seen, bsy_seen);
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++; $display("FAIL scoreboard leftover got %0d want 0", sb.size());
        end
    endtask

    initial begin
        cpu_mio = 0; mem_read = 0; mem_write = 0; ram_ctrl = '0; addr = '0; data_out = '0;
        cpu_mio0 = 0; mem_read0 = 0; mem_write0 = 0; ram_ctrl0 = '0; addr0 = '0; data_out0 = '0;
        test_reset();
        test_word();
        test_sizes();
        test_merge();
        test_align();
        test_reserved();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
